// File: rtl/computational_unit_p.sv
// Datapath for the simple microprocessor: register file, data_bus source mux,
// single-cycle ALU and an iterative shift-add multiply / restoring divide unit.
module computational_unit_p #(
  parameter int WIDTH     = 4,
  parameter int MD_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             x_sel,
  input  logic             y_sel,
  input  logic             i_sel,
  input  logic             i_post,
  input  logic [3:0]       source_sel,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] pm_data,
  input  logic [WIDTH-1:0] i_pins,
  input  logic [WIDTH-1:0] dm,
  input  logic [8:0]       reg_en,
  output logic [WIDTH-1:0] data_bus,
  output logic [WIDTH-1:0] x0,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] o_reg,
  output logic             r_eq_0,
  output logic             r_carry,
  output logic             r_neg,
  output logic             r_dz,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(MD_CYCLES + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [1:0] {MD_MUL_HI, MD_MUL_LO, MD_DIV, MD_MOD} md_kind_t;

  state_t           state;
  md_kind_t         md_kind, md_sel;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, operand;
  logic [WIDTH-1:0] x_op, y_op, alu_res, md_res, hi_nx, lo_nx;
  logic [WIDTH:0]   add_w, sub_w, mul_sum, div_shift, div_diff;
  logic             alu_carry, alu_wr, alu_md, div_ge, md_dz;
  logic             unused_spare;

  assign unused_spare = reg_en[7];
  assign x_op  = x_sel ? x1 : x0;
  assign y_op  = y_sel ? y1 : y0;
  assign add_w = {1'b0, x_op} + {1'b0, y_op};
  assign sub_w = {1'b0, x_op} - {1'b0, y_op};

  always_comb begin
    case (source_sel)
      4'd0:    data_bus = x0;
      4'd1:    data_bus = x1;
      4'd2:    data_bus = y0;
      4'd3:    data_bus = y1;
      4'd4:    data_bus = r;
      4'd5:    data_bus = m;
      4'd6:    data_bus = i;
      4'd7:    data_bus = dm;
      4'd8:    data_bus = pm_data;
      4'd9:    data_bus = i_pins;
      default: data_bus = '0;
    endcase
  end

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_wr    = 1'b0;
    alu_md    = 1'b0;
    md_sel    = MD_MUL_HI;
    case (alu_op)
      4'd0: begin alu_res = -x_op; alu_wr = 1'b1; end
      4'd1: begin {alu_carry, alu_res} = sub_w; alu_wr = 1'b1; end
      4'd2: begin {alu_carry, alu_res} = add_w; alu_wr = 1'b1; end
      4'd3: begin alu_md = 1'b1; md_sel = MD_MUL_HI; end
      4'd4: begin alu_md = 1'b1; md_sel = MD_MUL_LO; end
      4'd5: begin alu_res = x_op ^ y_op; alu_wr = 1'b1; end
      4'd6: begin alu_res = x_op & y_op; alu_wr = 1'b1; end
      4'd7: begin alu_res = ~x_op; alu_wr = 1'b1; end
      4'd8: begin alu_md = 1'b1; md_sel = MD_DIV; end
      4'd9: begin alu_md = 1'b1; md_sel = MD_MOD; end
      default: ;
    endcase
  end

  // Multiply: acc_hi:acc_lo shifts right, acc_lo starts as multiplier.
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  // A zero divisor naturally yields an all-ones quotient and remainder = dividend.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, operand};
  assign div_diff  = div_shift - {1'b0, operand};

  always_comb begin
    if (md_kind == MD_DIV || md_kind == MD_MOD) begin
      hi_nx = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_nx = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      hi_nx = mul_sum[WIDTH:1];
      lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
    md_res = (md_kind == MD_MUL_HI || md_kind == MD_MOD) ? hi_nx : lo_nx;
    md_dz  = (md_kind == MD_DIV || md_kind == MD_MOD) && (operand == '0);
  end

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      x0 <= '0; x1 <= '0; y0 <= '0; y1 <= '0;
      m <= '0; i <= '0; r <= '0; o_reg <= '0;
      r_eq_0 <= 1'b1; r_carry <= 1'b0; r_neg <= 1'b0; r_dz <= 1'b0;
      busy <= 1'b0; done <= 1'b0; state <= S_IDLE;
      md_kind <= MD_MUL_HI; cnt <= '0;
      acc_hi <= '0; acc_lo <= '0; operand <= '0;
    end else begin
      done <= 1'b0;
      if (reg_en[0]) x0 <= data_bus;
      if (reg_en[1]) x1 <= data_bus;
      if (reg_en[2]) y0 <= data_bus;
      if (reg_en[3]) y1 <= data_bus;
      if (reg_en[5]) m <= data_bus;
      if (reg_en[8]) o_reg <= data_bus;
      if (reg_en[6]) i <= i_sel ? i + m : data_bus;
      else if (i_post) i <= i + m;

      case (state)
        S_IDLE: begin
          if (reg_en[4] && alu_md) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            md_kind <= md_sel;
            cnt     <= CW'(MD_CYCLES);
            acc_hi  <= '0;
            if (md_sel == MD_DIV || md_sel == MD_MOD) begin
              acc_lo <= x_op; operand <= y_op;
            end else begin
              acc_lo <= y_op; operand <= x_op;
            end
          end else if (reg_en[4] && alu_wr) begin
            r       <= alu_res;
            r_eq_0  <= (alu_res == '0);
            r_neg   <= alu_res[WIDTH-1];
            r_carry <= alu_carry;
            r_dz    <= 1'b0;
          end
        end
        S_RUN: begin
          cnt    <= cnt - 1'b1;
          acc_hi <= hi_nx;
          acc_lo <= lo_nx;
          if (cnt == CW'(1)) begin
            r       <= md_res;
            r_eq_0  <= (md_res == '0);
            r_neg   <= md_res[WIDTH-1];
            r_carry <= 1'b0;
            r_dz    <= md_dz;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_computational_unit_p.sv
// Bench for computational_unit_p: directed steps plus randomized ALU ops on a
// WIDTH=4 instance, and multiply / reset-abort checks on a WIDTH=8 instance.
module tb_computational_unit_p;
  logic clk = 1'b0;
  logic rst4, rst8;
  logic x_sel, y_sel, i_sel, i_post;
  logic [3:0] source_sel, alu_op;
  logic [8:0] reg_en;
  logic [3:0] pm4, ip4, dm4;
  logic [7:0] pm8, ip8, dm8;

  logic [3:0] db4, x0_4, x1_4, y0_4, y1_4, m4, i4, r4, o4;
  logic eq4, c4, n4, dz4, busy4, done4;
  logic [7:0] db8, x0_8, x1_8, y0_8, y1_8, m8, i8, r8, o8;
  logic eq8, c8, n8, dz8, busy8, done8;

  int passed = 0, failed = 0, total = 0;
  int mr;
  bit mc, mdz;

  always #5 clk = ~clk;

  computational_unit_p #(.WIDTH(4)) dut4 (
    .clk(clk), .sync_reset(rst4), .x_sel(x_sel), .y_sel(y_sel), .i_sel(i_sel),
    .i_post(i_post), .source_sel(source_sel), .alu_op(alu_op), .pm_data(pm4),
    .i_pins(ip4), .dm(dm4), .reg_en(reg_en), .data_bus(db4), .x0(x0_4), .x1(x1_4),
    .y0(y0_4), .y1(y1_4), .m(m4), .i(i4), .r(r4), .o_reg(o4), .r_eq_0(eq4),
    .r_carry(c4), .r_neg(n4), .r_dz(dz4), .busy(busy4), .done(done4));

  computational_unit_p #(.WIDTH(8)) dut8 (
    .clk(clk), .sync_reset(rst8), .x_sel(x_sel), .y_sel(y_sel), .i_sel(i_sel),
    .i_post(i_post), .source_sel(source_sel), .alu_op(alu_op), .pm_data(pm8),
    .i_pins(ip8), .dm(dm8), .reg_en(reg_en), .data_bus(db8), .x0(x0_8), .x1(x1_8),
    .y0(y0_8), .y1(y1_8), .m(m8), .i(i8), .r(r8), .o_reg(o8), .r_eq_0(eq8),
    .r_carry(c8), .r_neg(n8), .r_dz(dz8), .busy(busy8), .done(done8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [8:0] en, input logic [3:0] v4, input logic [7:0] v8);
    source_sel = 4'd8; pm4 = v4; pm8 = v8; reg_en = en;
    step();
    reg_en = 9'h000;
  endtask

  // Reference ALU in plain integer arithmetic, modulo 2^w.
  function automatic void ref_alu(input int op, input int x, input int y, input int w,
                                  output bit wr, output int res, output bit c,
                                  output bit dz, output bit multi);
    int md = 1 << w;
    wr = 1; c = 0; dz = 0; multi = 0; res = 0;
    case (op)
      0: res = (md - x) % md;
      1: begin res = (x - y + md) % md; c = (x < y); end
      2: begin res = (x + y) % md; c = ((x + y) >= md); end
      3: begin res = (x * y) / md; multi = 1; end
      4: begin res = (x * y) % md; multi = 1; end
      5: res = x ^ y;
      6: res = x & y;
      7: res = md - 1 - x;
      8: begin multi = 1; if (y == 0) begin res = md - 1; dz = 1; end else res = x / y; end
      9: begin multi = 1; if (y == 0) begin res = x; dz = 1; end else res = x % y; end
      default: wr = 0;
    endcase
  endfunction

  task automatic op4(input int op, input int x, input int y, input string tag);
    bit wr, c, dz, multi;
    int res, n;
    x_sel = 1'($urandom_range(0, 1));
    y_sel = 1'($urandom_range(0, 1));
    load(x_sel ? 9'h002 : 9'h001, 4'(x), 8'd0);
    load(y_sel ? 9'h008 : 9'h004, 4'(y), 8'd0);
    ref_alu(op, x, y, 4, wr, res, c, dz, multi);
    alu_op = 4'(op); reg_en = 9'h010;
    step();
    reg_en = 9'h000;
    if (multi) begin
      chk({tag, "_busy"}, busy4, 1);
      n = 0;
      do begin step(); n++; end while (!done4 && n < 20);
      chk({tag, "_cycles"}, n, 4);
    end else begin
      chk({tag, "_busy"}, busy4, 0);
    end
    if (wr) begin mr = res; mc = c; mdz = dz; end
    chk({tag, "_r"}, r4, mr);
    chk({tag, "_carry"}, c4, mc);
    chk({tag, "_neg"}, n4, (mr >= 8));
    chk({tag, "_eq0"}, eq4, (mr == 0));
    chk({tag, "_dz"}, dz4, mdz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit saw_done;
    rst4 = 1; rst8 = 1;
    x_sel = 0; y_sel = 0; i_sel = 0; i_post = 0;
    source_sel = 4'd0; alu_op = 4'd12; reg_en = 9'h000;
    pm4 = 0; ip4 = 4'd6; dm4 = 4'd9; pm8 = 0; ip8 = 8'd0; dm8 = 8'd0;
    mr = 0; mc = 0; mdz = 0;
    step(); step();
    rst4 = 0;
    step();

    chk("rst_r", r4, 0);
    chk("rst_eq0", eq4, 1);
    chk("rst_flags", {c4, n4, dz4, busy4, done4}, 0);
    chk("rst_regs", {x0_4, x1_4, y0_4, y1_4, m4, i4, o4}, 0);
    source_sel = 4'd4; #1;
    chk("rst_bus", db4, 0);
    source_sel = 4'd9; #1;
    chk("bus_pins", db4, 6);
    source_sel = 4'd7; #1;
    chk("bus_dm", db4, 9);
    source_sel = 4'd13; #1;
    chk("bus_undef", db4, 0);

    op4(2, 9, 7, "add_wrap");
    op4(1, 3, 5, "sub_borrow");

    // Detailed multiply timing with a mid-op r-write attempt and operand change.
    x_sel = 0; y_sel = 0;
    load(9'h001, 4'd13, 8'd0);
    load(9'h004, 4'd11, 8'd0);
    alu_op = 4'd3; reg_en = 9'h010;
    step();
    reg_en = 9'h000;
    chk("mul_k_busy", {busy4, done4}, 2'b10);
    step();
    chk("mul_k1_busy", busy4, 1);
    alu_op = 4'd2; source_sel = 4'd8; pm4 = 4'd0; reg_en = 9'h011;
    step();
    reg_en = 9'h000;
    chk("mul_k2_busy", busy4, 1);
    chk("mul_k2_hold_r", r4, 14);
    chk("mul_k2_x0_written", x0_4, 0);
    step();
    chk("mul_k3_busy", {busy4, done4}, 2'b10);
    step();
    chk("mul_k4_done", {busy4, done4}, 2'b01);
    chk("mul_k4_r", r4, 8);
    step();
    chk("mul_k5_done_low", done4, 0);
    chk("mul_k5_r", r4, 8);
    mr = 8; mc = 0; mdz = 0;

    op4(4, 13, 11, "mul_lo");
    op4(8, 14, 4, "div");
    op4(9, 14, 4, "mod");
    op4(8, 14, 0, "div_zero");
    op4(2, 14, 0, "dz_clear");
    op4(13, 3, 3, "nop");

    // Index register: post-modify wrap, i+m load, reg_en priority.
    i_sel = 0;
    load(9'h020, 4'd3, 8'd0);
    load(9'h040, 4'd14, 8'd0);
    i_post = 1; step(); i_post = 0;
    chk("i_post_wrap", i4, 1);
    i_sel = 1; reg_en = 9'h040; step(); reg_en = 9'h000; i_sel = 0;
    chk("i_sel_add", i4, 4);
    source_sel = 4'd8; pm4 = 4'd5; reg_en = 9'h040; i_post = 1;
    step();
    reg_en = 9'h000; i_post = 0;
    chk("i_en_wins", i4, 5);
    load(9'h180, 4'd6, 8'd0);
    chk("o_reg", o4, 6);

    for (int k = 0; k < 30; k++) begin
      int ry;
      ry = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 15));
      op4(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), ry, "rand");
    end

    // WIDTH=8 instance.
    rst8 = 0;
    step();
    x_sel = 1; y_sel = 1;
    load(9'h002, 4'd0, 8'd200);
    load(9'h008, 4'd0, 8'd3);
    alu_op = 4'd4; reg_en = 9'h010; step(); reg_en = 9'h000;
    n = 0;
    do begin step(); n++; end while (!done8 && n < 30);
    chk("w8_mul_lo_cycles", n, 8);
    chk("w8_mul_lo_r", r8, 88);
    alu_op = 4'd3; reg_en = 9'h010; step(); reg_en = 9'h000;
    n = 0;
    do begin step(); n++; end while (!done8 && n < 30);
    chk("w8_mul_hi_cycles", n, 8);
    chk("w8_mul_hi_r", r8, 2);
    alu_op = 4'd4; reg_en = 9'h010; step(); reg_en = 9'h000;
    for (int k = 0; k < 4; k++) step();
    chk("w8_abort_busy_before", busy8, 1);
    rst8 = 1; #1;
    chk("w8_abort_busy", busy8, 0);
    chk("w8_abort_r", r8, 0);
    step();
    rst8 = 0;
    saw_done = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (done8 || busy8) saw_done = 1;
    end
    chk("w8_abort_no_done", saw_done, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
